// File: rtl/pipe_rc_adder_pkg.sv
// Shared defaults and parameter helpers for the pipelined ripple-carry adder.
// A WIDTH-bit add is split into STAGES equal segments of SEG_W bits.
package pipe_rc_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_rc_adder_segment.sv
// Combinational W-bit ripple of full-adder cells. cmsb is the carry into the
// top bit, which the final segment needs for signed-overflow detection.
module rc_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cmsb
);

  always_comb begin
    logic c;
    c    = ci;
    s    = '0;
    cmsb = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG_W-bit segment per stage,
// carry registered between stages, upper operand bits skewed alongside.
module pipe_rc_adder
  import pipe_rc_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG_W = seg_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_rc_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Handshake: a beat moves in on in_valid & in_ready and out on
  // out_valid & out_ready. The whole pipe advances together whenever the
  // output slot is empty or being drained, so in_ready is that same enable.
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin      = sub ? 1'b1 : carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SKEW_W = WIDTH - (k + 1) * SEG_W;

    logic                     vld;
    logic                     c_q;
    logic [(k+1)*SEG_W-1:0]   s_q;
    logic [(k+1)*SEG_W-1:0]   s_next;
    logic [SEG_W-1:0]         seg_a;
    logic [SEG_W-1:0]         seg_b;
    logic [SEG_W-1:0]         seg_s;
    logic                     seg_ci;
    logic                     seg_co;
    logic                     seg_cmsb;
    logic                     vld_in;

    if (k == 0) begin : g_src
      assign seg_a  = a[SEG_W-1:0];
      assign seg_b  = b_eff[SEG_W-1:0];
      assign seg_ci = cin;
      assign vld_in = in_valid;
      assign s_next = seg_s;
    end else begin : g_src
      assign seg_a  = g_stage[k-1].g_skew.a_q[SEG_W-1:0];
      assign seg_b  = g_stage[k-1].g_skew.b_q[SEG_W-1:0];
      assign seg_ci = g_stage[k-1].c_q;
      assign vld_in = g_stage[k-1].vld;
      assign s_next = {seg_s, g_stage[k-1].s_q};
    end

    rc_segment #(.W(SEG_W)) u_seg (
      .a    (seg_a),
      .b    (seg_b),
      .ci   (seg_ci),
      .s    (seg_s),
      .co   (seg_co),
      .cmsb (seg_cmsb)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        vld <= vld_in;
        c_q <= seg_co;
        s_q <= s_next;
      end
    end

    if (k < LAST) begin : g_skew
      // Operand bits not yet consumed; each stage peels off its low segment.
      logic [SKEW_W-1:0] a_q;
      logic [SKEW_W-1:0] b_q;
      logic [SKEW_W-1:0] a_d;
      logic [SKEW_W-1:0] b_d;
      logic              unused_cmsb;

      assign unused_cmsb = seg_cmsb;

      if (k == 0) begin : g_in
        assign a_d = a[WIDTH-1:SEG_W];
        assign b_d = b_eff[WIDTH-1:SEG_W];
      end else begin : g_in
        assign a_d = g_stage[k-1].g_skew.a_q[SEG_W +: SKEW_W];
        assign b_d = g_stage[k-1].g_skew.b_q[SEG_W +: SKEW_W];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic cmsb_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cmsb_q <= 1'b0;
        end else if (adv) begin
          cmsb_q <= seg_cmsb;
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].vld;
  assign sum       = g_stage[LAST].s_q;
  assign carry_out = g_stage[LAST].c_q;
  assign overflow  = g_stage[LAST].c_q ^ g_stage[LAST].g_last.cmsb_q;
  // Qualified by valid so the cleared pipe does not report zero.
  assign zero      = out_valid & ~(|sum);

endmodule

// File: tb/tb_pipe_rc_adder.sv
// Self-checking bench for pipe_rc_adder (WIDTH=16, STAGES=4) with a queue
// scoreboard fed by an arithmetic reference model.
module tb_pipe_rc_adder;

  localparam int W      = 16;
  localparam int STAGES = 4;
  localparam int RW     = W + 3;

  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] vs;
    logic         vco;
    logic         vov;
    logic         vz;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];

  logic          t_took, t_got, t_ovld, t_irdy, t_empty;
  logic [RW-1:0] t_obs, t_exp;
  logic [W-1:0]  pa, pb;
  logic          pcin, psub;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pipe_rc_adder #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub);
    int ua, ub, sa, sb, ru, rs;
    logic co, ov;
    logic [W-1:0] s;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      ru = ua - ub;
      rs = sa - sb;
      co = (ua >= ub);
    end else begin
      ru = ua + ub + int'(mcin);
      rs = sa + sb + int'(mcin);
      co = (ru >= (1 << W));
    end
    ov = (rs > (1 << (W - 1)) - 1) || (rs < -(1 << (W - 1)));
    s  = ru[W-1:0];
    return {s, co, ov, (s == '0)};
  endfunction

  // ---------------- driver ----------------
  task automatic new_beat();
    pa   = W'($urandom);
    pb   = W'($urandom);
    pcin = 1'($urandom_range(0, 1));
    psub = 1'($urandom_range(0, 1));
  endtask

  // Drives one cycle, does scoreboard bookkeeping, returns what was seen.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, input logic iordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    carry_in  = icin;
    sub       = isub;
    out_ready = iordy;
    #1;
    t_ovld  = out_valid;
    t_irdy  = in_ready;
    t_took  = iv && in_ready;
    t_got   = out_valid && iordy;
    t_obs   = {sum, carry_out, overflow, zero};
    t_exp   = '0;
    t_empty = 1'b0;
    if (t_got) begin
      if (exp_q.size() == 0) t_empty = 1'b1;
      else t_exp = exp_q.pop_front();
    end
    if (t_took) exp_q.push_back(model(ia, ib, icin, isub));
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry_out: got %b want 0", carry_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", zero); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    vec_t tv[6];
    int   lat;
    bit   found;
    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tv[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tv[3] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tv[4] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
    tv[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    foreach (tv[n]) begin
      cycle(1'b1, tv[n].va, tv[n].vb, tv[n].vcin, tv[n].vsub, 1'b1);
      n_checks++; if (t_took !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept: in_ready %b want 1", n, t_irdy); end
      found = 1'b0;
      lat   = 0;
      for (int i = 1; i <= 12 && !found; i++) begin
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        if (t_got) begin
          found = 1'b1;
          lat   = i;
          n_checks++;
          if (t_obs !== {tv[n].vs, tv[n].vco, tv[n].vov, tv[n].vz}) begin
            n_fail++;
            $display("FAIL dir%0d_result: got sum=%h co=%b ov=%b z=%b want sum=%h co=%b ov=%b z=%b",
                     n, t_obs[RW-1:3], t_obs[2], t_obs[1], t_obs[0], tv[n].vs, tv[n].vco, tv[n].vov, tv[n].vz);
          end
          n_checks++;
          if (t_empty || t_obs !== t_exp) begin
            n_fail++;
            $display("FAIL dir%0d_model: got %h want %h (queue empty=%b)", n, t_obs, t_exp, t_empty);
          end
        end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL dir%0d_timeout: no result within 12 cycles, want 4", n); end
      n_checks++; if (found && lat != STAGES) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", n, lat, STAGES); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, outs = 0, first = -1;
    for (int cyc = 0; cyc < 60 && outs < 20; cyc++) begin
      if (sent < 20) new_beat();
      cycle(sent < 20, pa, pb, pcin, psub, 1'b1);
      if (sent < 20) begin
        n_checks++; if (t_took !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", cyc, t_irdy); end
        sent++;
      end
      if (t_got) begin
        if (first < 0) begin
          first = cyc;
          n_checks++; if (first != STAGES) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", first, STAGES); end
        end
        n_checks++; if (cyc != first + outs) begin n_fail++; $display("FAIL b2b_gap: result %0d at cycle %0d want %0d", outs, cyc, first + outs); end
        n_checks++;
        if (t_empty || t_obs !== t_exp) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %h want %h (queue empty=%b)", outs, t_obs, t_exp, t_empty);
        end
        outs++;
      end
    end
    n_checks++; if (outs != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", outs); end
  endtask

  task automatic test_stall();
    int accepted = 0, delivered = 0, stalled = 0;
    new_beat();
    for (int cyc = 0; cyc < 40 && stalled < 6; cyc++) begin
      cycle(1'b1, pa, pb, pcin, psub, 1'b0);
      if (t_took) begin accepted++; new_beat(); end
      if (t_ovld) begin
        stalled++;
        n_checks++; if (t_irdy !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", t_irdy); end
        n_checks++;
        if (exp_q.size() == 0 || t_obs !== exp_q[0]) begin
          n_fail++;
          $display("FAIL stall_frozen: got %h want head %h", t_obs, (exp_q.size() != 0) ? exp_q[0] : '0);
        end
      end
    end
    n_checks++; if (stalled != 6) begin n_fail++; $display("FAIL stall_reached: stalled cycles %0d want 6", stalled); end
    n_checks++; if (accepted != STAGES) begin n_fail++; $display("FAIL stall_fill: accepted %0d want %0d", accepted, STAGES); end
    for (int cyc = 0; cyc < 60 && (accepted < 8 || delivered < accepted); cyc++) begin
      cycle(accepted < 8, pa, pb, pcin, psub, 1'b1);
      if (t_took) begin accepted++; new_beat(); end
      if (t_got) begin
        delivered++;
        n_checks++;
        if (t_empty || t_obs !== t_exp) begin
          n_fail++;
          $display("FAIL stall_drain%0d: got %h want %h (queue empty=%b)", delivered, t_obs, t_exp, t_empty);
        end
      end
    end
    n_checks++; if (delivered != 8 || accepted != 8) begin n_fail++; $display("FAIL stall_count: delivered %0d accepted %0d want 8", delivered, accepted); end
  endtask

  task automatic test_random_backpressure();
    logic iv, ordy;
    new_beat();
    iv = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!iv) iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      cycle(iv, pa, pb, pcin, psub, ordy);
      if (t_took) begin iv = 1'b0; new_beat(); end
      if (t_got) begin
        n_checks++;
        if (t_empty || t_obs !== t_exp) begin
          n_fail++;
          $display("FAIL rand_result: cycle %0d got %h want %h (queue empty=%b)", cyc, t_obs, t_exp, t_empty);
        end
      end
    end
    for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (t_got) begin
        n_checks++;
        if (t_empty || t_obs !== t_exp) begin
          n_fail++;
          $display("FAIL rand_drain: got %h want %h (queue empty=%b)", t_obs, t_exp, t_empty);
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost: %0d beats never delivered, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int lat = 0;
    for (int i = 0; i < STAGES; i++) begin
      new_beat();
      cycle(1'b1, pa, pb, pcin, psub, 1'b0);
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_full: out_valid %b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL midrst_sum: got %h want 0000", sum); end
    n_checks++; if ({carry_out, overflow, zero} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {carry_out, overflow, zero}); end
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (t_ovld !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: cycle %0d out_valid %b want 0", i, t_ovld); end
    end
    new_beat();
    cycle(1'b1, pa, pb, pcin, psub, 1'b1);
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (t_got) begin
        lat = i;
        n_checks++;
        if (t_empty || t_obs !== t_exp) begin
          n_fail++;
          $display("FAIL midrst_after: got %h want %h (queue empty=%b)", t_obs, t_exp, t_empty);
        end
      end
    end
    n_checks++; if (lat != STAGES) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, STAGES); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
